// File: rtl/mem_port_arbiter.sv
// Shares one registered-read data-memory port between instruction fetch and load/store.
// Build option ARB_ROUND_ROBIN_EN swaps fixed data priority (with burst limit) for round-robin.
module mem_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int max_data_burst = 4
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_gnt,
    output logic            fetch_r_valid,
    output logic [XLEN-1:0] fetch_r_data,

    input  logic            data_req,
    input  logic [XLEN-1:0] data_addr,
    input  logic [XLEN-1:0] data_w_data,
    input  logic [1:0]      data_w_width,
    input  logic            data_w_enable,
    input  logic [1:0]      data_r_width,
    input  logic            data_r_sign_extend,
    output logic            data_gnt,
    output logic            data_r_valid,
    output logic [XLEN-1:0] data_r_data,

    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_w_data,
    output logic [1:0]      mem_w_width,
    output logic            mem_w_enable,
    output logic [1:0]      mem_r_width,
    output logic            mem_r_sign_extend,
    input  logic [XLEN-1:0] mem_r_data
);

    localparam logic [1:0] WIDTH_WORD = 2'd2;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    owner_t     resp_owner_p1, owner_nxt;
    logic [1:0] resp_width_p1, width_nxt;
    logic       resp_sext_p1, sext_nxt;
    logic       grant_fetch, grant_data;

`ifdef ARB_ROUND_ROBIN_EN
    // last_winner: 1 = data won most recently, 0 = fetch (reset value, so data wins first)
    logic last_winner_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_winner_data <= 1'b0;
        end else if (grant_data) begin
            last_winner_data <= 1'b1;
        end else if (grant_fetch) begin
            last_winner_data <= 1'b0;
        end
    end
`else
    localparam logic [3:0] BURST_MAX = 4'(max_data_burst);
    logic [3:0] burst_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_cnt <= 4'd0;
        end else if (grant_fetch || !fetch_req) begin
            burst_cnt <= 4'd0;
        end else if (grant_data) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end
`endif

    // Request stage: arbitrate and steer the winner onto the port
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (fetch_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_data  = !last_winner_data;
`else
            grant_data  = (burst_cnt != BURST_MAX);
`endif
            grant_fetch = !grant_data;
        end else begin
            grant_fetch = fetch_req;
            grant_data  = data_req;
        end
        if (reset) begin
            grant_fetch = 1'b0;
            grant_data  = 1'b0;
        end
    end

    assign fetch_gnt    = grant_fetch;
    assign data_gnt     = grant_data;
    assign mem_addr     = grant_data ? data_addr : fetch_addr;
    assign mem_w_data   = grant_data ? data_w_data : '0;
    assign mem_w_width  = grant_data ? data_w_width : WIDTH_WORD;
    assign mem_w_enable = grant_data && data_w_enable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_owner_p1 <= OWN_NONE;
            resp_width_p1 <= WIDTH_WORD;
            resp_sext_p1  <= 1'b0;
        end else begin
            resp_owner_p1 <= owner_nxt;
            resp_width_p1 <= width_nxt;
            resp_sext_p1  <= sext_nxt;
        end
    end

    always_comb begin
        owner_nxt = OWN_NONE;
        width_nxt = WIDTH_WORD;
        sext_nxt  = 1'b0;
        if (grant_fetch) begin
            owner_nxt = OWN_FETCH;
        end else if (grant_data && !data_w_enable) begin
            owner_nxt = OWN_DATA;
            width_nxt = data_r_width;
            sext_nxt  = data_r_sign_extend;
        end
    end

    // Response stage: memory data belongs to whoever was granted last cycle
    assign mem_r_width       = resp_width_p1;
    assign mem_r_sign_extend = resp_sext_p1;
    assign fetch_r_valid     = !reset && (resp_owner_p1 == OWN_FETCH);
    assign data_r_valid      = !reset && (resp_owner_p1 == OWN_DATA);
    assign fetch_r_data      = mem_r_data;
    assign data_r_data       = mem_r_data;

endmodule
